// File: rtl/eth_tx_hdr_checker.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_hdr_checker
// Brief    : Passive checker pairing MFB TX frames with MVB headers; measures
//            frame length, compares it with the header field, keeps stats.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_hdr_checker #(
  parameter int REGION_SIZE    = 8,
  parameter int BLOCK_SIZE     = 8,
  parameter int ITEM_WIDTH     = 8,
  parameter int HDR_WIDTH      = 64,
  parameter int HDR_LEN_OFFSET = 0,
  parameter int HDR_FIFO_DEPTH = 16
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic                                      RX_MFB_SOF,
  input  logic                                      RX_MFB_EOF,
  input  logic [$clog2(REGION_SIZE)-1:0]            RX_MFB_SOF_POS,
  input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0] RX_MFB_EOF_POS,
  input  logic                                      RX_MFB_SRC_RDY,
  input  logic                                      RX_MFB_DST_RDY,
  input  logic [HDR_WIDTH-1:0]                      RX_MVB_DATA,
  input  logic                                      RX_MVB_VLD,
  input  logic                                      RX_MVB_SRC_RDY,
  input  logic                                      RX_MVB_DST_RDY,
  input  logic                                      CLR,
  output logic [31:0]                               CNT_FRAMES,
  output logic [31:0]                               CNT_ERRORS,
  output logic [4:0]                                ERR_FLAGS,
  output logic                                      ERR_PULSE,
  output logic [$clog2(HDR_FIFO_DEPTH):0]           HDR_OCCUPANCY
);

  localparam int              c_AW    = $clog2(HDR_FIFO_DEPTH);
  localparam logic [16:0]     c_W     = 17'(REGION_SIZE * BLOCK_SIZE);
  localparam logic [16:0]     c_BS    = 17'(BLOCK_SIZE);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(HDR_FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_acc;
  logic [15:0]         w_acc_nxt;
  logic                w_pop;
  logic [15:0]         w_len;
  logic                w_err_sof;
  logic                w_err_eof;

  logic [15:0]         r_mem [HDR_FIFO_DEPTH];
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW:0]       r_count;

  logic [31:0]         r_cnt_frames;
  logic [31:0]         r_cnt_errors;
  logic [4:0]          r_err_flags;
  logic                r_err_pulse;

  logic                w_mfb_xfer;
  logic                w_mvb_push;
  logic [16:0]         w_sof_off;
  logic [16:0]         w_eof_inc;
  logic                w_eof_first;
  logic [15:0]         w_push_len;
  logic                w_empty;
  logic                w_full;
  logic                w_hdr_ok;
  logic                w_do_pop;
  logic                w_do_write;
  logic                w_err_ovf;
  logic                w_err_nohdr;
  logic                w_err_len;
  logic [15:0]         w_head_len;
  logic [4:0]          w_err;
  logic [2:0]          w_err_cnt;
  logic [32:0]         w_frames_sum;
  logic [32:0]         w_errors_sum;
  logic                w_unused;

  assign w_mfb_xfer  = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;
  assign w_mvb_push  = RX_MVB_VLD & RX_MVB_SRC_RDY & RX_MVB_DST_RDY;
  assign w_sof_off   = 17'(RX_MFB_SOF_POS) * c_BS;
  assign w_eof_inc   = 17'(RX_MFB_EOF_POS) + 17'd1;
  // EOF sitting before the SOF block belongs to the frame already open
  assign w_eof_first = RX_MFB_SOF & RX_MFB_EOF & (17'(RX_MFB_EOF_POS) < w_sof_off);
  assign w_push_len  = RX_MVB_DATA[HDR_LEN_OFFSET +: 16];
  assign w_unused    = ^{RX_MVB_DATA, 1'(ITEM_WIDTH)};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_pop       = 1'b0;
    w_len       = '0;
    w_err_sof   = 1'b0;
    w_err_eof   = 1'b0;
    if (w_mfb_xfer) begin
      if (w_eof_first) begin
        if (r_state == ST_IN_FRAME) begin
          w_pop = 1'b1;
          w_len = sat16(17'(r_acc) + w_eof_inc);
        end else begin
          w_err_eof = 1'b1;
        end
        w_state_nxt = ST_IN_FRAME;
        w_acc_nxt   = 16'(c_W - w_sof_off);
      end else if (RX_MFB_SOF) begin
        w_err_sof = (r_state == ST_IN_FRAME);
        if (RX_MFB_EOF) begin
          w_pop       = 1'b1;
          w_len       = 16'(w_eof_inc - w_sof_off);
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
        end else begin
          w_state_nxt = ST_IN_FRAME;
          w_acc_nxt   = 16'(c_W - w_sof_off);
        end
      end else if (RX_MFB_EOF) begin
        if (r_state == ST_IN_FRAME) begin
          w_pop       = 1'b1;
          w_len       = sat16(17'(r_acc) + w_eof_inc);
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
        end else begin
          w_err_eof = 1'b1;
        end
      end else if (r_state == ST_IN_FRAME) begin
        w_acc_nxt = sat16(17'(r_acc) + c_W);
      end
    end
  end

  // A header pushed in the same cycle as an EOF on an empty FIFO is consumed directly
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_DEPTH);
  assign w_hdr_ok    = w_pop & (~w_empty | w_mvb_push);
  assign w_do_pop    = w_pop & ~w_empty;
  assign w_do_write  = w_mvb_push & ~(w_pop & w_empty) & (~w_full | w_do_pop);
  assign w_err_ovf   = w_mvb_push & w_full & ~w_do_pop;
  assign w_head_len  = w_empty ? w_push_len : r_mem[r_rd_ptr];
  assign w_err_len   = w_hdr_ok & (w_head_len != w_len);
  assign w_err_nohdr = w_pop & ~w_hdr_ok;

  assign w_err     = {w_err_eof, w_err_sof, w_err_ovf, w_err_nohdr, w_err_len};
  assign w_err_cnt = 3'(w_err[0]) + 3'(w_err[1]) + 3'(w_err[2]) + 3'(w_err[3]) + 3'(w_err[4]);

  always_ff @(posedge CLK) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= w_push_len;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_do_write, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_frames_sum = {1'b0, r_cnt_frames} + 33'(w_hdr_ok);
  assign w_errors_sum = {1'b0, r_cnt_errors} + 33'(w_err_cnt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt_frames <= '0;
      r_cnt_errors <= '0;
      r_err_flags  <= '0;
      r_err_pulse  <= 1'b0;
    end else if (CLR) begin
      r_cnt_frames <= '0;
      r_cnt_errors <= '0;
      r_err_flags  <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_cnt_frames <= w_frames_sum[32] ? 32'hFFFF_FFFF : w_frames_sum[31:0];
      r_cnt_errors <= w_errors_sum[32] ? 32'hFFFF_FFFF : w_errors_sum[31:0];
      r_err_flags  <= r_err_flags | w_err;
      r_err_pulse  <= |w_err;
    end
  end

  assign CNT_FRAMES    = r_cnt_frames;
  assign CNT_ERRORS    = r_cnt_errors;
  assign ERR_FLAGS     = r_err_flags;
  assign ERR_PULSE     = r_err_pulse;
  assign HDR_OCCUPANCY = r_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_hdr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_hdr_checker
// Brief    : Self-checking bench: directed scenarios plus randomized frames
//            predicted from frame lengths and a header queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_hdr_checker;

  localparam int W = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RX_MFB_SOF, RX_MFB_EOF;
  logic [2:0]  RX_MFB_SOF_POS;
  logic [5:0]  RX_MFB_EOF_POS;
  logic        RX_MFB_SRC_RDY, RX_MFB_DST_RDY;
  logic [63:0] RX_MVB_DATA;
  logic        RX_MVB_VLD, RX_MVB_SRC_RDY, RX_MVB_DST_RDY;
  logic        CLR;
  logic [31:0] CNT_FRAMES, CNT_ERRORS;
  logic [4:0]  ERR_FLAGS;
  logic        ERR_PULSE;
  logic [4:0]  HDR_OCCUPANCY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  eth_tx_hdr_checker #(
    .REGION_SIZE(8), .BLOCK_SIZE(8), .ITEM_WIDTH(8),
    .HDR_WIDTH(64), .HDR_LEN_OFFSET(0), .HDR_FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_MFB_SOF(RX_MFB_SOF), .RX_MFB_EOF(RX_MFB_EOF),
    .RX_MFB_SOF_POS(RX_MFB_SOF_POS), .RX_MFB_EOF_POS(RX_MFB_EOF_POS),
    .RX_MFB_SRC_RDY(RX_MFB_SRC_RDY), .RX_MFB_DST_RDY(RX_MFB_DST_RDY),
    .RX_MVB_DATA(RX_MVB_DATA), .RX_MVB_VLD(RX_MVB_VLD),
    .RX_MVB_SRC_RDY(RX_MVB_SRC_RDY), .RX_MVB_DST_RDY(RX_MVB_DST_RDY),
    .CLR(CLR),
    .CNT_FRAMES(CNT_FRAMES), .CNT_ERRORS(CNT_ERRORS), .ERR_FLAGS(ERR_FLAGS),
    .ERR_PULSE(ERR_PULSE), .HDR_OCCUPANCY(HDR_OCCUPANCY)
  );

  task automatic idle_inputs();
    RX_MFB_SOF = 0; RX_MFB_EOF = 0; RX_MFB_SOF_POS = '0; RX_MFB_EOF_POS = '0;
    RX_MFB_SRC_RDY = 0; RX_MFB_DST_RDY = 0;
    RX_MVB_DATA = '0; RX_MVB_VLD = 0; RX_MVB_SRC_RDY = 0; RX_MVB_DST_RDY = 0;
    CLR = 0;
  endtask

  // Inputs are applied just after an edge; outputs are read 1 ns after the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic set_word(input bit sof, input bit eof, input int sp, input int ep);
    RX_MFB_SRC_RDY = 1; RX_MFB_DST_RDY = 1;
    RX_MFB_SOF = sof; RX_MFB_EOF = eof;
    RX_MFB_SOF_POS = 3'(sp); RX_MFB_EOF_POS = 6'(ep);
  endtask

  task automatic set_hdr(input int len);
    RX_MVB_DATA = {$urandom, $urandom};
    RX_MVB_DATA[15:0] = 16'(len);
    RX_MVB_VLD = 1; RX_MVB_SRC_RDY = 1; RX_MVB_DST_RDY = 1;
  endtask

  task automatic stall_garbage();
    logic [2:0] v;
    RX_MFB_SRC_RDY = 1'($urandom_range(1));
    RX_MFB_DST_RDY = RX_MFB_SRC_RDY ? 1'b0 : 1'($urandom_range(1));
    RX_MFB_SOF = 1'($urandom_range(1)); RX_MFB_EOF = 1'($urandom_range(1));
    RX_MFB_SOF_POS = 3'($urandom_range(7)); RX_MFB_EOF_POS = 6'($urandom_range(63));
    v = 3'($urandom_range(7));
    if (v == 3'b111) v = 3'b011;
    {RX_MVB_VLD, RX_MVB_SRC_RDY, RX_MVB_DST_RDY} = v;
    RX_MVB_DATA = {$urandom, $urandom};
  endtask

  task automatic do_clr();
    CLR = 1;
    step();
  endtask

  function automatic int frame_words(input int len, input int sp);
    int cap = W - 8 * sp;
    if (len <= cap) return 1;
    return 2 + (len - cap - 1) / W;
  endfunction

  // Splits a frame of len items starting at block sp into MFB words.
  task automatic send_frame(input int len, input int sp, input int hdr_len,
                            input int hdr_at, input bit stalls);
    int cap, n, last_ep;
    cap = W - 8 * sp;
    n = frame_words(len, sp);
    last_ep = (n == 1) ? (8 * sp + len - 1) : ((len - cap - 1) % W);
    for (int k = 0; k < n; k++) begin
      if (stalls) begin
        while ($urandom_range(3) == 0) begin
          stall_garbage();
          step();
        end
      end
      set_word(k == 0, k == n - 1, sp, (k == n - 1) ? last_ep : int'($urandom_range(63)));
      if (k == hdr_at) set_hdr(hdr_len);
      step();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({CNT_FRAMES, CNT_ERRORS, ERR_FLAGS, ERR_PULSE, HDR_OCCUPANCY} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: frames=%0d errors=%0d flags=%b pulse=%b occ=%0d, all must be 0",
               CNT_FRAMES, CNT_ERRORS, ERR_FLAGS, ERR_PULSE, HDR_OCCUPANCY);
    end
  endtask

  task automatic test_single_word();
    do_clr();
    set_hdr(60); step();
    n_checks++;
    if (HDR_OCCUPANCY !== 5'd1) begin n_errors++; $display("FAIL single_occ_push: got %0d exp 1", HDR_OCCUPANCY); end
    set_word(1, 1, 0, 59); step();
    n_checks++;
    if (CNT_FRAMES !== 32'd1) begin n_errors++; $display("FAIL single_frames: got %0d exp 1", CNT_FRAMES); end
    n_checks++;
    if (ERR_FLAGS !== 5'b0) begin n_errors++; $display("FAIL single_flags: got %b exp 00000", ERR_FLAGS); end
    n_checks++;
    if (HDR_OCCUPANCY !== 5'd0) begin n_errors++; $display("FAIL single_occ_pop: got %0d exp 0", HDR_OCCUPANCY); end
  endtask

  task automatic test_multi_word();
    do_clr();
    set_hdr(130); step();
    set_word(1, 0, 2, $urandom_range(63)); step();
    set_word(0, 0, 0, $urandom_range(63)); step();
    set_word(0, 1, 0, 17); step();
    n_checks++;
    if (CNT_FRAMES !== 32'd1) begin n_errors++; $display("FAIL multi_frames: got %0d exp 1", CNT_FRAMES); end
    n_checks++;
    if (ERR_FLAGS !== 5'b0 || CNT_ERRORS !== 32'd0) begin
      n_errors++; $display("FAIL multi_errors: flags=%b cnt=%0d exp 00000/0", ERR_FLAGS, CNT_ERRORS);
    end
  endtask

  task automatic test_len_mismatch();
    do_clr();
    set_hdr(100); step();
    set_word(1, 1, 0, 63); step();
    n_checks++;
    if (ERR_FLAGS !== 5'b00001) begin n_errors++; $display("FAIL mism_flags: got %b exp 00001", ERR_FLAGS); end
    n_checks++;
    if (CNT_ERRORS !== 32'd1 || CNT_FRAMES !== 32'd1) begin
      n_errors++; $display("FAIL mism_counts: errors=%0d frames=%0d exp 1/1", CNT_ERRORS, CNT_FRAMES);
    end
    n_checks++;
    if (ERR_PULSE !== 1'b1) begin n_errors++; $display("FAIL mism_pulse_on: got %b exp 1", ERR_PULSE); end
    step();
    n_checks++;
    if (ERR_PULSE !== 1'b0 || ERR_FLAGS !== 5'b00001) begin
      n_errors++; $display("FAIL mism_pulse_off: pulse=%b flags=%b exp 0/00001", ERR_PULSE, ERR_FLAGS);
    end
  endtask

  task automatic test_no_hdr();
    do_clr();
    set_word(1, 0, 0, 0); step();
    set_word(0, 1, 0, 9); step();
    n_checks++;
    if (ERR_FLAGS !== 5'b00010 || CNT_ERRORS !== 32'd1 || CNT_FRAMES !== 32'd0) begin
      n_errors++; $display("FAIL nohdr_empty: flags=%b errors=%0d frames=%0d exp 00010/1/0",
                           ERR_FLAGS, CNT_ERRORS, CNT_FRAMES);
    end
    do_clr();
    set_word(1, 0, 0, 0); step();
    set_word(0, 1, 0, 9); set_hdr(74); step();
    n_checks++;
    if (ERR_FLAGS !== 5'b0 || CNT_FRAMES !== 32'd1 || HDR_OCCUPANCY !== 5'd0) begin
      n_errors++; $display("FAIL nohdr_bypass: flags=%b frames=%0d occ=%0d exp 00000/1/0",
                           ERR_FLAGS, CNT_FRAMES, HDR_OCCUPANCY);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < 17; i++) begin
      set_hdr(1000 + i); step();
    end
    n_checks++;
    if (HDR_OCCUPANCY !== 5'd16 || ERR_FLAGS !== 5'b00100 || CNT_ERRORS !== 32'd1) begin
      n_errors++; $display("FAIL ovf_state: occ=%0d flags=%b errors=%0d exp 16/00100/1",
                           HDR_OCCUPANCY, ERR_FLAGS, CNT_ERRORS);
    end
    send_frame(1000, 0, 0, -1, 0);
    n_checks++;
    if (CNT_FRAMES !== 32'd1 || ERR_FLAGS !== 5'b00100 || HDR_OCCUPANCY !== 5'd15) begin
      n_errors++; $display("FAIL ovf_first_pop: frames=%0d flags=%b occ=%0d exp 1/00100/15",
                           CNT_FRAMES, ERR_FLAGS, HDR_OCCUPANCY);
    end
    for (int i = 1; i < 16; i++) send_frame(1000 + i, 0, 0, -1, 0);
    n_checks++;
    if (CNT_FRAMES !== 32'd16 || ERR_FLAGS !== 5'b00100 || HDR_OCCUPANCY !== 5'd0) begin
      n_errors++; $display("FAIL ovf_drain: frames=%0d flags=%b occ=%0d exp 16/00100/0",
                           CNT_FRAMES, ERR_FLAGS, HDR_OCCUPANCY);
    end
  endtask

  task automatic test_eof_then_sof();
    do_clr();
    set_hdr(72); step();
    set_hdr(58); step();
    set_word(1, 0, 0, $urandom_range(63)); step();
    set_word(1, 1, 2, 7); step();
    n_checks++;
    if (CNT_FRAMES !== 32'd1 || ERR_FLAGS !== 5'b0 || HDR_OCCUPANCY !== 5'd1) begin
      n_errors++; $display("FAIL shared_word: frames=%0d flags=%b occ=%0d exp 1/00000/1",
                           CNT_FRAMES, ERR_FLAGS, HDR_OCCUPANCY);
    end
    set_word(0, 1, 0, 9); step();
    n_checks++;
    if (CNT_FRAMES !== 32'd2 || ERR_FLAGS !== 5'b0 || HDR_OCCUPANCY !== 5'd0) begin
      n_errors++; $display("FAIL shared_second: frames=%0d flags=%b occ=%0d exp 2/00000/0",
                           CNT_FRAMES, ERR_FLAGS, HDR_OCCUPANCY);
    end
    // SOF in frame plus a headerless close within the same word
    set_word(1, 0, 0, 0); step();
    set_word(1, 1, 0, 10); step();
    n_checks++;
    if (CNT_ERRORS !== 32'd2 || ERR_FLAGS !== 5'b01010 || ERR_PULSE !== 1'b1 || CNT_FRAMES !== 32'd2) begin
      n_errors++; $display("FAIL double_err: errors=%0d flags=%b pulse=%b frames=%0d exp 2/01010/1/2",
                           CNT_ERRORS, ERR_FLAGS, ERR_PULSE, CNT_FRAMES);
    end
  endtask

  task automatic test_random();
    int hq[$];
    int exp_frames = 0;
    int exp_mism = 0;
    do_clr();
    for (int f = 0; f < 40; f++) begin
      int len, sp, hl, at, n, h;
      bit mism, e;
      len  = $urandom_range(300, 1);
      sp   = $urandom_range(7);
      mism = ($urandom_range(3) == 0);
      hl   = mism ? (len + 1 + int'($urandom_range(40))) : len;
      n    = frame_words(len, sp);
      at   = -1;
      if ($urandom_range(3) == 0) begin
        set_hdr(hl); step();
      end else begin
        at = $urandom_range(n - 1);
      end
      hq.push_back(hl);
      repeat ($urandom_range(2)) begin stall_garbage(); step(); end
      send_frame(len, sp, hl, at, 1);
      h = hq.pop_front();
      e = (h != len);
      exp_frames++;
      if (e) exp_mism++;
      n_checks++;
      if (ERR_PULSE !== e || CNT_FRAMES !== 32'(exp_frames) || CNT_ERRORS !== 32'(exp_mism)) begin
        n_errors++; $display("FAIL rand_frame%0d len=%0d hdr=%0d: pulse=%b frames=%0d errors=%0d exp %b/%0d/%0d",
                             f, len, h, ERR_PULSE, CNT_FRAMES, CNT_ERRORS, e, exp_frames, exp_mism);
      end
    end
    n_checks++;
    if (ERR_FLAGS !== {4'b0, exp_mism > 0} || HDR_OCCUPANCY !== 5'd0) begin
      n_errors++; $display("FAIL rand_final: flags=%b occ=%0d exp %b/0", ERR_FLAGS, HDR_OCCUPANCY,
                           {4'b0, exp_mism > 0});
    end
  endtask

  task automatic test_sof_eof_errors();
    do_clr();
    set_word(1, 0, 0, 0); step();
    set_word(1, 0, 0, 0); step();
    set_word(0, 1, 0, 9); set_hdr(74); step();
    set_word(0, 1, 0, 5); step();
    n_checks++;
    if (ERR_FLAGS !== 5'b11000 || CNT_ERRORS !== 32'd2 || CNT_FRAMES !== 32'd1) begin
      n_errors++; $display("FAIL seq_errors: flags=%b errors=%0d frames=%0d exp 11000/2/1",
                           ERR_FLAGS, CNT_ERRORS, CNT_FRAMES);
    end
    set_word(0, 1, 0, 3); CLR = 1; step();
    n_checks++;
    if (ERR_FLAGS !== 5'b0 || CNT_ERRORS !== 32'd0 || CNT_FRAMES !== 32'd0 || ERR_PULSE !== 1'b0) begin
      n_errors++; $display("FAIL clr_priority: flags=%b errors=%0d frames=%0d pulse=%b exp all 0",
                           ERR_FLAGS, CNT_ERRORS, CNT_FRAMES, ERR_PULSE);
    end
    set_hdr(5); step();
    set_word(1, 0, 0, 0); step();
    set_word(0, 1, 0, 63); step();
    set_word(1, 1, 0, 63); step();
    #2 RESET = 1;
    #1;
    test_reset();
    @(posedge CLK); #1;
    RESET = 0;
    set_word(1, 0, 0, 0); step();
    #2 RESET = 1;
    #1;
    n_checks++;
    if (HDR_OCCUPANCY !== 5'd0 || ERR_FLAGS !== 5'b0) begin
      n_errors++; $display("FAIL reset_midframe: occ=%0d flags=%b exp 0/00000", HDR_OCCUPANCY, ERR_FLAGS);
    end
    @(posedge CLK); #1;
    RESET = 0;
    set_word(0, 1, 0, 4); step();
    n_checks++;
    if (ERR_FLAGS !== 5'b10000 || CNT_ERRORS !== 32'd1 || CNT_FRAMES !== 32'd0) begin
      n_errors++; $display("FAIL post_reset_eof: flags=%b errors=%0d frames=%0d exp 10000/1/0",
                           ERR_FLAGS, CNT_ERRORS, CNT_FRAMES);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    RESET = 1;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    RESET = 0;
    test_single_word();
    test_multi_word();
    test_len_mismatch();
    test_no_hdr();
    test_overflow();
    test_eof_then_sof();
    test_random();
    test_sof_eof_errors();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
